// File: rtl/fp_align_unit_if.sv
// Operand/result bundle between the FP adder front end and its neighbours.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: master drives operands and out_ready; slave (fp_align_unit) drives in_ready and results.
interface fp_align_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        signA;
    logic        signB;
    logic        ANaN;
    logic        BNaN;
    logic        Ainf;
    logic        Binf;
    logic        Azero;
    logic        Bzero;
    logic        alignedSign;
    logic [31:0] alignedResult;
    logic        carryOut;
    logic [7:0]  exponentOut;
    logic        sticky;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, opA, opB, signA, signB,
               ANaN, BNaN, Ainf, Binf, Azero, Bzero,
               alignedSign, alignedResult, carryOut, exponentOut, sticky
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, opA, opB, signA, signB,
               ANaN, BNaN, Ainf, Binf, Azero, Bzero,
               alignedSign, alignedResult, carryOut, exponentOut, sticky
    );
endinterface

// File: rtl/fp_align_unit.sv
// Single-precision adder front end: classify, order by magnitude, align, add/subtract.
// Latency: specials 1 cycle; otherwise 2 + ceil(min(d,32)/SHIFT_STEP) cycles accept->out_valid.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, reset (async active-high), io (fp_align_unit_if.slave) carrying operands and results.
module fp_align_unit #(
    parameter int SHIFT_STEP = 8
) (
    input  logic           clk,
    input  logic           reset,
    fp_align_unit_if.slave io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t state;
    state_t nextState;

    // ---------------------------------------------------------------
    // Operand unpack and classification (on the live inputs, used at accept)
    // ---------------------------------------------------------------
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [22:0] mantA;
    logic [22:0] mantB;
    logic        nanA;
    logic        nanB;
    logic        infA;
    logic        infB;
    logic        zeroA;
    logic        zeroB;
    logic        special;

    assign expA  = io.A[30:23];
    assign expB  = io.B[30:23];
    assign mantA = io.A[22:0];
    assign mantB = io.B[22:0];

    assign nanA  = (expA == 8'hFF) && (mantA != 23'd0);
    assign nanB  = (expB == 8'hFF) && (mantB != 23'd0);
    assign infA  = (expA == 8'hFF) && (mantA == 23'd0);
    assign infB  = (expB == 8'hFF) && (mantB == 23'd0);
    assign zeroA = (expA == 8'd0) && (mantA == 23'd0);
    assign zeroB = (expB == 8'd0) && (mantB == 23'd0);
    assign special = nanA | nanB | infA | infB | zeroA | zeroB;

    // Denormals carry a 0 hidden bit and behave as exponent 1.
    logic [7:0]  effExpA;
    logic [7:0]  effExpB;
    logic [31:0] sigA;
    logic [31:0] sigB;

    assign effExpA = (expA == 8'd0) ? 8'd1 : expA;
    assign effExpB = (expB == 8'd0) ? 8'd1 : expB;
    assign sigA    = {(expA != 8'd0), mantA, 8'd0};
    assign sigB    = {(expB != 8'd0), mantB, 8'd0};

    // Raw {exp,mant} compare orders by magnitude; equal magnitudes make A big.
    logic        aIsBig;
    logic [7:0]  expBigIn;
    logic [7:0]  expSmallIn;
    logic [7:0]  expDiff;
    logic [5:0]  remainingInit;

    assign aIsBig        = (io.A[30:0] >= io.B[30:0]);
    assign expBigIn      = aIsBig ? effExpA : effExpB;
    assign expSmallIn    = aIsBig ? effExpB : effExpA;
    assign expDiff       = expBigIn - expSmallIn;
    // Anything at or past 32 flushes the whole small significand into sticky.
    assign remainingInit = (expDiff >= 8'd32) ? 6'd32 : expDiff[5:0];

    // ---------------------------------------------------------------
    // Working registers
    // ---------------------------------------------------------------
    logic [31:0] bigSig;
    logic [31:0] smallSig;
    logic [7:0]  expBig;
    logic        signBig;
    logic        effSub;
    logic        stickyAcc;
    logic [5:0]  remaining;

    // One alignment step: the low half of the pair holds the bits that fell off.
    logic [5:0]  stepNow;
    logic [63:0] shiftPair;

    assign stepNow   = (remaining > STEP) ? STEP : remaining;
    assign shiftPair = {smallSig, 32'd0} >> stepNow;

    // Significand add keeps the carry in bit 32. The subtract never borrows
    // because big >= small after ordering, so 32 bits hold the full difference.
    logic [32:0] sumWide;
    logic [31:0] diffRes;

    assign sumWide = {1'b0, bigSig} + {1'b0, smallSig};
    assign diffRes = bigSig - smallSig - {31'd0, stickyAcc};

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    logic inReady;
    logic outValid;
    logic accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (io.in_valid) begin
                    accept = 1'b1;
                    if (special) begin
                        nextState = DONE;
                    end else if (expDiff == 8'd0) begin
                        nextState = ADD;
                    end else begin
                        nextState = ALIGN;
                    end
                end
            end
            ALIGN: begin
                // Last step consumes exactly what is left.
                if (remaining == stepNow) begin
                    nextState = ADD;
                end
            end
            ADD: begin
                nextState = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                if (io.out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign io.in_ready  = inReady;
    assign io.out_valid = outValid;

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io.opA           <= 32'd0;
            io.opB           <= 32'd0;
            io.signA         <= 1'b0;
            io.signB         <= 1'b0;
            io.ANaN          <= 1'b0;
            io.BNaN          <= 1'b0;
            io.Ainf          <= 1'b0;
            io.Binf          <= 1'b0;
            io.Azero         <= 1'b0;
            io.Bzero         <= 1'b0;
            io.alignedSign   <= 1'b0;
            io.alignedResult <= 32'd0;
            io.carryOut      <= 1'b0;
            io.exponentOut   <= 8'd0;
            io.sticky        <= 1'b0;
            bigSig           <= 32'd0;
            smallSig         <= 32'd0;
            expBig           <= 8'd0;
            signBig          <= 1'b0;
            effSub           <= 1'b0;
            stickyAcc        <= 1'b0;
            remaining        <= 6'd0;
        end else if (accept) begin
            io.opA           <= io.A;
            io.opB           <= io.B;
            io.signA         <= io.A[31];
            io.signB         <= io.B[31];
            io.ANaN          <= nanA;
            io.BNaN          <= nanB;
            io.Ainf          <= infA;
            io.Binf          <= infB;
            io.Azero         <= zeroA;
            io.Bzero         <= zeroB;
            // Result fields stay zero for specials; normal ops fill them in ADD.
            io.alignedSign   <= 1'b0;
            io.alignedResult <= 32'd0;
            io.carryOut      <= 1'b0;
            io.exponentOut   <= 8'd0;
            io.sticky        <= 1'b0;
            bigSig           <= aIsBig ? sigA : sigB;
            smallSig         <= aIsBig ? sigB : sigA;
            expBig           <= expBigIn;
            signBig          <= aIsBig ? io.A[31] : io.B[31];
            effSub           <= io.A[31] ^ io.B[31];
            stickyAcc        <= 1'b0;
            remaining        <= remainingInit;
        end else if (state == ALIGN) begin
            smallSig  <= shiftPair[63:32];
            stickyAcc <= stickyAcc | (|shiftPair[31:0]);
            remaining <= remaining - stepNow;
        end else if (state == ADD) begin
            if (!effSub) begin
                io.alignedResult <= sumWide[31:0];
                io.carryOut      <= sumWide[32];
                io.alignedSign   <= (sumWide == 33'd0) ? 1'b0 : signBig;
            end else begin
                io.alignedResult <= diffRes;
                io.carryOut      <= 1'b0;
                // Exact cancellation is reported as +0.
                io.alignedSign   <= (diffRes == 32'd0) ? 1'b0 : signBig;
            end
            io.exponentOut <= expBig;
            io.sticky      <= stickyAcc;
        end
    end

endmodule

// File: tb/tb_fp_align_unit.sv
// Bench for fp_align_unit: directed cases plus randomized operand pairs against a reference model.
// Latency: measured per op from accept edge to out_valid.
// Backpressure: random out_ready stalls; outputs checked every cycle out_valid is high.
module tb_fp_align_unit;

    localparam int STEP = 8;

    typedef struct packed {
        logic [31:0] opA;
        logic [31:0] opB;
        logic        signA;
        logic        signB;
        logic        ANaN;
        logic        BNaN;
        logic        Ainf;
        logic        Binf;
        logic        Azero;
        logic        Bzero;
        logic        alignedSign;
        logic [31:0] alignedResult;
        logic        carryOut;
        logic [7:0]  exponentOut;
        logic        sticky;
    } res_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic chkOn;
    res_t expCur;

    fp_align_unit_if io();

    fp_align_unit #(.SHIFT_STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic res_t grab();
        res_t r;
        r.opA           = io.opA;
        r.opB           = io.opB;
        r.signA         = io.signA;
        r.signB         = io.signB;
        r.ANaN          = io.ANaN;
        r.BNaN          = io.BNaN;
        r.Ainf          = io.Ainf;
        r.Binf          = io.Binf;
        r.Azero         = io.Azero;
        r.Bzero         = io.Bzero;
        r.alignedSign   = io.alignedSign;
        r.alignedResult = io.alignedResult;
        r.carryOut      = io.carryOut;
        r.exponentOut   = io.exponentOut;
        r.sticky        = io.sticky;
        return r;
    endfunction

    // Reference: the whole alignment is one wide shift of a 64-bit scaled value.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, output int lat);
        res_t        r;
        logic [31:0] bg;
        logic [31:0] sm;
        int          eb;
        int          es;
        int          dd;
        logic [63:0] sigBig;
        logic [63:0] smallScaled;
        logic [63:0] sum;
        logic        st;
        r = '0;
        r.opA   = a;
        r.opB   = b;
        r.signA = a[31];
        r.signB = b[31];
        r.ANaN  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        r.BNaN  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        r.Ainf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        r.Binf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        r.Azero = (a[30:0] == 31'd0);
        r.Bzero = (b[30:0] == 31'd0);
        if (r.ANaN | r.BNaN | r.Ainf | r.Binf | r.Azero | r.Bzero) begin
            lat = 1;
            return r;
        end
        if (a[30:0] >= b[30:0]) begin bg = a; sm = b; end
        else begin bg = b; sm = a; end
        eb = (bg[30:23] == 8'd0) ? 1 : int'(bg[30:23]);
        es = (sm[30:23] == 8'd0) ? 1 : int'(sm[30:23]);
        dd = eb - es;
        if (dd > 32) dd = 32;
        sigBig      = {32'd0, (bg[30:23] != 8'd0), bg[22:0], 8'd0};
        smallScaled = {(sm[30:23] != 8'd0), sm[22:0], 8'd0, 32'd0} >> dd;
        st          = (smallScaled[31:0] != 32'd0);
        if (bg[31] == sm[31]) sum = sigBig + (smallScaled >> 32);
        else                  sum = sigBig - (smallScaled >> 32) - 64'(st);
        r.alignedResult = sum[31:0];
        r.carryOut      = sum[32];
        r.alignedSign   = (sum == 64'd0) ? 1'b0 : bg[31];
        r.exponentOut   = 8'(eb);
        r.sticky        = st;
        lat = 2 + (dd + STEP - 1) / STEP;
        return r;
    endfunction

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (chkOn && io.out_valid) begin
            chk("fields", 128'(grab()), 128'(expCur));
            chk("in_ready_low_in_done", 128'(io.in_ready), 128'(1'b0));
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int stall, output int lat);
        int guard;
        int expLat;
        guard = 0;
        @(negedge clk);
        io.A = a;
        io.B = b;
        io.in_valid = 1'b1;
        while (!io.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 128'(guard), 128'(0));
        expCur = model(a, b, expLat);
        chkOn = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(expLat));
        repeat (stall) @(negedge clk);
        @(negedge clk);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        chkOn = 1'b0;
        chk("out_valid_after_handshake", 128'(io.out_valid), 128'(1'b0));
        chk("in_ready_after_handshake", 128'(io.in_ready), 128'(1'b1));
    endtask

    function automatic logic [31:0] randOp(input int baseExp);
        logic [31:0] v;
        int k;
        int e;
        v = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3: begin v[30:23] = 8'h00; v[0] = 1'b1; end
            default: begin
                e = baseExp + $urandom_range(0, 80) - 40;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
        endcase
        return v;
    endfunction

    initial begin
        res_t m;
        int   ml;
        int   lat;
        int   base;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rs;

        total = 0;
        bad = 0;
        chkOn = 1'b0;
        expCur = '0;
        reset = 1'b1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.A = 32'd0;
        io.B = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(io.in_ready), 128'(1'b1));
        chk("reset_out_valid", 128'(io.out_valid), 128'(1'b0));
        chk("reset_fields", 128'(grab()), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", 128'(io.out_valid), 128'(1'b0));

        // Hand-computed pins on the model
        m = model(32'h3F800000, 32'h3F800000, ml);
        chk("pin1_result", 128'(m.alignedResult), 128'(32'h00000000));
        chk("pin1_carry_exp_sticky", 128'({m.carryOut, m.exponentOut, m.sticky}), 128'({1'b1, 8'h7F, 1'b0}));
        chk("pin1_lat", 128'(ml), 128'(2));
        m = model(32'h3F800000, 32'h30800000, ml);
        chk("pin2_result", 128'(m.alignedResult), 128'(32'h80000002));
        chk("pin2_sticky_lat", 128'({m.sticky, 8'(ml)}), 128'({1'b0, 8'd6}));
        m = model(32'h3F800000, 32'h2B800000, ml);
        chk("pin3_result", 128'(m.alignedResult), 128'(32'h80000000));
        chk("pin3_sticky_lat", 128'({m.sticky, 8'(ml)}), 128'({1'b1, 8'd6}));
        m = model(32'h3F800000, 32'hBF800000, ml);
        chk("pin4", 128'({m.alignedResult, m.carryOut, m.alignedSign, m.exponentOut}),
            128'({32'd0, 1'b0, 1'b0, 8'h7F}));
        m = model(32'h7F800000, 32'hFF800000, ml);
        chk("pin5", 128'({m.Ainf, m.Binf, m.signA, m.signB, 8'(ml)}), 128'({4'b1101, 8'd1}));

        // Directed cases on the DUT
        issue(32'h3F800000, 32'h3F800000, 0, lat);
        chk("t1_lat", 128'(lat), 128'(2));
        issue(32'h3F800000, 32'h30800000, 1, lat);
        chk("t2_lat", 128'(lat), 128'(6));
        issue(32'h3F800000, 32'h2B800000, 0, lat);
        chk("t3_lat", 128'(lat), 128'(6));
        issue(32'h3F800000, 32'hBF800000, 2, lat);
        issue(32'h7F800000, 32'hFF800000, 5, lat);
        chk("t5_lat", 128'(lat), 128'(1));

        // Reset while aligning: op dropped, block idle afterwards
        @(negedge clk);
        io.A = 32'h3F800000;
        io.B = 32'h30800000;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", 128'(io.out_valid), 128'(1'b0));
        chk("rst_mid_in_ready", 128'(io.in_ready), 128'(1'b1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("rst_after_idle", 128'({io.out_valid, io.in_ready}), 128'(2'b01));
        end
        issue(32'h3F800000, 32'h3F800000, 0, lat);
        chk("t6_lat", 128'(lat), 128'(2));

        // Randomized pairs
        for (int i = 0; i < 200; i++) begin
            base = $urandom_range(1, 254);
            ra = randOp(base);
            rb = randOp(base);
            if ($urandom_range(0, 7) == 0) begin
                rs = $urandom;
                rb = {rs[0], ra[30:0]};
            end
            issue(ra, rb, $urandom_range(0, 3), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
